// File: rtl/mem_access_responder.sv
// Memory access responder: one bus transaction per fetch/load/store phase, busy held until done.
// Optional MEM_TIMEOUT_EN aborts a stuck WAIT after TIMEOUT_CYCLES and raises a sticky bus_error.
module mem_access_responder #(
  parameter int unsigned ADDR_W         = 27,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              getRegs,
  input  logic              readMem,
  input  logic              writeBack,
  output logic              busy,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done,
  output logic              bus_error
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
  typedef enum logic [1:0] {KindFetch, KindRead, KindWrite} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_sel;
  logic              need;
  logic              timeout;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_data_q, instr_q, mem_q_q;
  logic              bus_we_q, bus_start_q;

  // getRegs is a phase with no memory side effect; it only needs to be observed.
  logic unused_get_regs;
  assign unused_get_regs = getRegs;

  // Strobe priority on overlap: fetch > readMem > writeBack.
  always_comb begin
    need     = fetch | (readMem & mem_rd) | (writeBack & mem_wr);
    kind_sel = KindWrite;
    if (fetch) begin
      kind_sel = KindFetch;
    end else if (readMem & mem_rd) begin
      kind_sel = KindRead;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       bus_error_q;

  assign timeout   = (state_q == StWait) && !bus_done &&
                     (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign bus_error = bus_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      if (state_q == StIdle && need) begin
        wait_cnt_q <= 8'd0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end
`else
  localparam int unsigned UnusedTimeout = TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (need) begin
          busy    = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (bus_done || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      kind_q      <= KindFetch;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_start_q <= 1'b0;
      instr_q     <= '0;
      mem_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_start_q <= 1'b0;
      if (state_q == StIdle && need) begin
        kind_q      <= kind_sel;
        bus_addr_q  <= fetch ? pc : mem_addr;
        bus_data_q  <= mem_wdata;
        bus_we_q    <= (kind_sel == KindWrite);
        bus_start_q <= 1'b1;
      end
      if (state_q == StWait && bus_done) begin
        if (kind_q == KindFetch) begin
          instr_q <= bus_q;
        end else if (kind_q == KindRead) begin
          mem_q_q <= bus_q;
        end
      end else if (timeout) begin
        // Aborted access hands the CPU a zero word rather than stale data.
        if (kind_q == KindFetch) begin
          instr_q <= '0;
        end else if (kind_q == KindRead) begin
          mem_q_q <= '0;
        end
      end
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_data  = bus_data_q;
  assign bus_we    = bus_we_q;
  assign bus_start = bus_start_q;
  assign instr     = instr_q;
  assign mem_q     = mem_q_q;

endmodule
